// File: rtl/butterfly_pair_reader.sv
// Read-side address generator and pair collector for one radix-2 DIT FFT stage.
// For each butterfly it reads the top leg then the bottom leg (one address per cycle),
// pairs the returned samples and presents them with the top-leg pointer and twiddle index.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, stage        begin a pass (IDLE only); stage is clamped to SIZE-1
//   rd_en, rd_addr      memory read strobe and address
//   rd_re, rd_im        read data, valid the cycle after rd_en
//   Re_o_1, Im_o_1      top-leg sample of the presented pair
//   Re_o_2, Im_o_2      bottom-leg sample of the presented pair
//   rd_ptr, tw_idx      top-leg address and twiddle exponent of the presented pair
//   out_valid, done     pair strobe; done marks the last pair of the pass
//   busy                high while a pass is in progress
module butterfly_pair_reader #(
  parameter int unsigned bit_width = 16,
  parameter int unsigned SIZE      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [3:0]                  stage,
  output logic                        rd_en,
  output logic [SIZE-1:0]             rd_addr,
  input  logic signed [bit_width-1:0] rd_re,
  input  logic signed [bit_width-1:0] rd_im,
  output logic signed [bit_width-1:0] Re_o_1,
  output logic signed [bit_width-1:0] Im_o_1,
  output logic signed [bit_width-1:0] Re_o_2,
  output logic signed [bit_width-1:0] Im_o_2,
  output logic [SIZE-1:0]             rd_ptr,
  output logic [SIZE-2:0]             tw_idx,
  output logic                        out_valid,
  output logic                        busy,
  output logic                        done
);

  localparam logic [SIZE-2:0] LastB = {(SIZE-1){1'b1}};

  typedef enum logic [1:0] {StIdle, StReadTop, StReadBot, StDrain} state_e;

  function automatic logic [SIZE-1:0] span_of(input logic [3:0] s);
    return SIZE'(1) << s;
  endfunction

  function automatic logic [SIZE-1:0] top_of(input logic [SIZE-2:0] b, input logic [3:0] s);
    logic [SIZE-1:0] bx;
    logic [SIZE-1:0] pos;
    bx  = {1'b0, b};
    pos = bx & (span_of(s) - SIZE'(1));
    return ((bx >> s) << (s + 4'd1)) | pos;
  endfunction

  function automatic logic [SIZE-2:0] tw_of(input logic [SIZE-2:0] b, input logic [3:0] s);
    logic [SIZE-1:0] pos;
    logic [SIZE-1:0] tmp;
    pos = {1'b0, b} & (span_of(s) - SIZE'(1));
    tmp = pos << (4'(SIZE-1) - s);
    return tmp[SIZE-2:0];
  endfunction

  state_e          state_q, state_d;
  logic [SIZE-2:0] b_q, b_d;
  logic [3:0]      s_q, s_d;
  logic            drain_q, drain_d;

  // Address of the access happening this cycle, and its pair metadata.
  logic [SIZE-1:0] rd_addr_q;
  logic [SIZE-1:0] top_q;
  logic [SIZE-2:0] tw_q;

  // Metadata delayed one cycle to line up with the returned data.
  logic                        top_ret_q, bot_ret_q, last_ret_q;
  logic [SIZE-1:0]             ptr_ret_q;
  logic [SIZE-2:0]             tw_ret_q;
  logic signed [bit_width-1:0] hold_re_q, hold_im_q;

  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    s_d     = s_q;
    drain_d = drain_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StReadTop;
          b_d     = '0;
          s_d     = (32'(stage) >= SIZE) ? 4'(SIZE-1) : stage;
        end
      end
      StReadTop: state_d = StReadBot;
      StReadBot: begin
        if (b_q == LastB) begin
          state_d = StDrain;
          drain_d = 1'b0;
        end else begin
          state_d = StReadTop;
          b_d     = b_q + 1'b1;
        end
      end
      StDrain: begin
        // Two cycles: one for the last read data, one for the output register.
        if (drain_q) state_d = StIdle;
        else         drain_d = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      b_q       <= '0;
      s_q       <= '0;
      drain_q   <= 1'b0;
      rd_addr_q <= '0;
      top_q     <= '0;
      tw_q      <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      s_q     <= s_d;
      drain_q <= drain_d;
      if (state_d == StReadTop) begin
        rd_addr_q <= top_of(b_d, s_d);
        top_q     <= top_of(b_d, s_d);
        tw_q      <= tw_of(b_d, s_d);
      end else if (state_d == StReadBot) begin
        rd_addr_q <= top_q + span_of(s_q);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ret_q  <= 1'b0;
      bot_ret_q  <= 1'b0;
      last_ret_q <= 1'b0;
      ptr_ret_q  <= '0;
      tw_ret_q   <= '0;
      hold_re_q  <= '0;
      hold_im_q  <= '0;
      Re_o_1     <= '0;
      Im_o_1     <= '0;
      Re_o_2     <= '0;
      Im_o_2     <= '0;
      rd_ptr     <= '0;
      tw_idx     <= '0;
      out_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      top_ret_q  <= (state_q == StReadTop);
      bot_ret_q  <= (state_q == StReadBot);
      last_ret_q <= (state_q == StReadBot) && (b_q == LastB);
      if (state_q == StReadBot) begin
        ptr_ret_q <= top_q;
        tw_ret_q  <= tw_q;
      end
      if (top_ret_q) begin
        hold_re_q <= rd_re;
        hold_im_q <= rd_im;
      end
      out_valid <= bot_ret_q;
      done      <= bot_ret_q && last_ret_q;
      if (bot_ret_q) begin
        Re_o_1 <= hold_re_q;
        Im_o_1 <= hold_im_q;
        Re_o_2 <= rd_re;
        Im_o_2 <= rd_im;
        rd_ptr <= ptr_ret_q;
        tw_idx <= tw_ret_q;
      end
    end
  end

  assign rd_en   = (state_q == StReadTop) || (state_q == StReadBot);
  assign rd_addr = rd_addr_q;
  assign busy    = (state_q != StIdle);

endmodule
